// File: rtl/neural_soc_led_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : neural_soc_led_sequencer_if
//  Purpose  : Avalon-MM style bus bundle used for both the configuration
//             slave port and the LED PIO master port of the LED sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface neural_soc_led_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   // The master side is write-only: the LED PIO data register is never read back.
   modport master (output address, chipselect, write_n, writedata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface
`default_nettype wire

// File: rtl/neural_soc_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : neural_soc_led_sequencer
//  Purpose  : Replays up to eight 8-bit LED patterns to an LED PIO through
//             single-cycle Avalon-MM writes, with a programmable hold period,
//             optional looping and a completion interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module neural_soc_led_sequencer #(
   parameter int NUM_STEPS = 8,
   parameter int PERIOD_W  = 24
) (
   input  wire logic                  clk,
   input  wire logic                  reset_n,
   neural_soc_led_sequencer_if.slave  s,
   neural_soc_led_sequencer_if.master m,
   output logic                       irq
);

   localparam int c_STEP_W = $clog2(NUM_STEPS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_STEP_W-1:0]   r_step;
   logic [c_STEP_W-1:0]   w_step_nxt;
   logic [PERIOD_W-1:0]   r_cnt;
   logic [PERIOD_W-1:0]   w_cnt_nxt;
   logic                  r_run;
   logic                  r_loop;
   logic                  r_irq_en;
   logic                  r_done;
   logic [PERIOD_W-1:0]   r_period;
   logic [3:0]            r_length;
   logic [7:0]            r_pattern [NUM_STEPS];

   logic                  w_wr;
   logic                  w_ctrl_wr;
   logic                  w_stat_wr;
   logic                  w_advance;
   logic                  w_done_set;
   logic                  w_busy;
   logic [PERIOD_W-1:0]   w_period_eff;
   logic [c_STEP_W-1:0]   w_last_step;
   logic                  w_unused;

   assign w_wr      = s.chipselect & ~s.write_n;
   assign w_ctrl_wr = w_wr && (s.address == 4'd0);
   assign w_stat_wr = w_wr && (s.address == 4'd1);
   assign w_busy    = (r_state != ST_IDLE);
   assign w_unused  = ^s.writedata[31:PERIOD_W];

   // A zero PERIOD behaves as one cycle per step.
   assign w_period_eff = (r_period == '0) ? PERIOD_W'(1) : r_period;
   // LENGTH of 0 or above eight means all eight slots.
   assign w_last_step  = ((r_length == 4'd0) || (r_length > 4'd8)) ? c_STEP_W'(NUM_STEPS - 1)
                                                                 : r_length[c_STEP_W-1:0] - c_STEP_W'(1);

   // State, step and hold-counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_step  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Sequencing decisions; a CONTROL write overrides any natural completion.
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_cnt_nxt   = r_cnt;
      w_advance   = 1'b0;
      w_done_set  = 1'b0;
      case (r_state)
         ST_WRITE: begin
            if (w_period_eff == PERIOD_W'(1)) begin
               w_advance = 1'b1;
            end else begin
               w_cnt_nxt   = w_period_eff - PERIOD_W'(2);
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) begin
               w_advance = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - PERIOD_W'(1);
            end
         end
         default: ;
      endcase
      if (w_advance) begin
         if (r_step < w_last_step) begin
            w_step_nxt  = r_step + c_STEP_W'(1);
            w_state_nxt = ST_WRITE;
         end else if (r_loop) begin
            w_step_nxt  = '0;
            w_state_nxt = ST_WRITE;
         end else begin
            w_state_nxt = ST_IDLE;
            w_done_set  = 1'b1;
         end
      end
      if (w_ctrl_wr) begin
         w_done_set = 1'b0;
         if (s.writedata[0]) begin
            w_step_nxt  = '0;
            w_state_nxt = ST_WRITE;
         end else begin
            w_step_nxt  = r_step;
            w_state_nxt = ST_IDLE;
         end
      end
   end

   // Configuration registers and the sticky DONE flag (a set beats a clear).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_run    <= 1'b0;
         r_loop   <= 1'b0;
         r_irq_en <= 1'b0;
         r_done   <= 1'b0;
         r_period <= '0;
         r_length <= '0;
         for (int i = 0; i < NUM_STEPS; i++) begin
            r_pattern[i] <= '0;
         end
      end else begin
         if (w_ctrl_wr) begin
            r_run    <= s.writedata[0];
            r_loop   <= s.writedata[1];
            r_irq_en <= s.writedata[2];
         end else if (w_done_set) begin
            r_run <= 1'b0;
         end
         if (w_done_set) begin
            r_done <= 1'b1;
         end else if (w_stat_wr && s.writedata[1]) begin
            r_done <= 1'b0;
         end
         if (w_wr && (s.address == 4'd2)) begin
            r_period <= s.writedata[PERIOD_W-1:0];
         end
         if (w_wr && (s.address == 4'd3)) begin
            r_length <= s.writedata[3:0];
         end
         if (w_wr && s.address[3]) begin
            r_pattern[s.address[2:0]] <= s.writedata[7:0];
         end
      end
   end

   // Zero-wait-state register read mux.
   always_comb begin
      s.readdata = '0;
      case (s.address)
         4'd0:    s.readdata[2:0]          = {r_irq_en, r_loop, r_run};
         4'd1:    s.readdata[6:0]          = {r_step, 2'b00, r_done, w_busy};
         4'd2:    s.readdata[PERIOD_W-1:0] = r_period;
         4'd3:    s.readdata[3:0]          = r_length;
         default: if (s.address[3]) s.readdata[7:0] = r_pattern[s.address[2:0]];
      endcase
   end

   // The master strobe lives only in the WRITE state, so reset drops it at once.
   always_comb begin
      m.address    = '0;
      m.chipselect = (r_state == ST_WRITE);
      m.write_n    = (r_state != ST_WRITE);
      m.writedata  = (r_state == ST_WRITE) ? {24'b0, r_pattern[r_step]} : 32'b0;
   end

   assign irq = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_neural_soc_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neural_soc_led_sequencer
//  Purpose  : Self-checking bench for the LED sequencer: directed scenarios
//             plus random register traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neural_soc_led_sequencer;

   logic clk = 1'b0;
   logic reset_n;
   logic irq;

   neural_soc_led_sequencer_if #(.ADDR_W(4)) s_if ();
   neural_soc_led_sequencer_if #(.ADDR_W(2)) m_if ();

   always #5 clk = ~clk;

   assign m_if.readdata = '0;

   neural_soc_led_sequencer #(.NUM_STEPS(8), .PERIOD_W(24)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .s       (s_if),
      .m       (m_if),
      .irq     (irq)
   );

   // Behavioural model: phase counts cycles since the last strobe of the current step.
   bit          md_run, md_loop, md_irqen, md_done, md_busy;
   int          md_period, md_length, md_step, md_phase, md_hold;
   int          md_pat [8];
   int          n_vec = 0;
   int          n_err = 0;
   int          strobes = 0;
   logic [7:0]  led = '0;
   logic [31:0] obs_rd = '0;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int eff_p();
      return (md_period == 0) ? 1 : md_period;
   endfunction

   function automatic int eff_len();
      return ((md_length == 0) || (md_length > 8)) ? 8 : md_length;
   endfunction

   function automatic int hold_now();
      return (md_phase == 0) ? eff_p() : md_hold;
   endfunction

   function automatic bit model_strobe();
      return md_busy && (md_phase == 0);
   endfunction

   function automatic bit model_final_now();
      return md_busy && (md_phase == hold_now() - 1) && (md_step >= eff_len() - 1) && !md_loop;
   endfunction

   function automatic logic [31:0] model_rd(input int a);
      logic [31:0] r = '0;
      logic [2:0]  st = md_step[2:0];
      case (a)
         0: r[2:0] = {md_irqen, md_loop, md_run};
         1: r[6:0] = {st, 2'b00, md_done, md_busy};
         2: r      = md_period;
         3: r      = md_length;
         default: if (a >= 8) r = md_pat[a-8];
      endcase
      return r;
   endfunction

   task automatic model_reset();
      md_run = 0; md_loop = 0; md_irqen = 0; md_done = 0; md_busy = 0;
      md_period = 0; md_length = 0; md_step = 0; md_phase = 0; md_hold = 0;
      for (int i = 0; i < 8; i++) md_pat[i] = 0;
   endtask

   task automatic model_clock(input int a, input logic cs, input logic wn, input logic [31:0] wd);
      bit fin = 0;
      int old_step = md_step;
      int hold;
      if (md_busy) begin
         hold = hold_now();
         if (md_phase == 0) md_hold = hold;
         if (md_phase == hold - 1) begin
            md_phase = 0;
            if (md_step < eff_len() - 1)  md_step++;
            else if (md_loop)             md_step = 0;
            else begin fin = 1; md_busy = 0; end
         end else begin
            md_phase++;
         end
      end
      if (cs && !wn) begin
         case (a)
            0: begin
               md_run = wd[0]; md_loop = wd[1]; md_irqen = wd[2];
               fin = 0;
               md_phase = 0;
               if (wd[0]) begin md_busy = 1; md_step = 0; end
               else begin md_busy = 0; md_step = old_step; end
            end
            1: if (wd[1]) md_done = 0;
            2: md_period = int'(wd[23:0]);
            3: md_length = int'(wd[3:0]);
            default: if (a >= 8) md_pat[a-8] = int'(wd[7:0]);
         endcase
      end
      if (fin) begin md_done = 1; md_run = 0; end
   endtask

   // One bus cycle: drive at the falling edge, compare mid-cycle, advance the model at the rising edge.
   task automatic bus_cycle(input int a, input logic cs, input logic wn, input logic [31:0] wd);
      bit stb;
      @(negedge clk);
      s_if.address = a[3:0]; s_if.chipselect = cs; s_if.write_n = wn; s_if.writedata = wd;
      #1;
      stb = model_strobe();
      check_value("m_chipselect", {31'b0, m_if.chipselect}, {31'b0, stb});
      check_value("m_write_n",    {31'b0, m_if.write_n},    {31'b0, !stb});
      check_value("m_address",    {30'b0, m_if.address},    32'd0);
      check_value("m_writedata",  m_if.writedata,           stb ? md_pat[md_step] : 0);
      check_value("irq",          {31'b0, irq},             {31'b0, md_done && md_irqen});
      check_value("s_readdata",   s_if.readdata,            model_rd(a));
      obs_rd = s_if.readdata;
      if (m_if.chipselect && !m_if.write_n) begin
         led = m_if.writedata[7:0];
         strobes++;
      end
      @(posedge clk);
      model_clock(a, cs, wn, wd);
   endtask

   task automatic write_reg(input int a, input logic [31:0] d);
      bus_cycle(a, 1'b1, 1'b0, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus_cycle(int'($urandom_range(0, 15)), 1'b1, 1'b1, $urandom);
   endtask

   task automatic wait_final(input string tag);
      int n = 0;
      while (!model_final_now() && n < 60) begin
         idle(1);
         n++;
      end
      if (!model_final_now()) check_value(tag, 32'd0, 32'd1);
   endtask

   initial begin
      s_if.address = '0; s_if.chipselect = 1'b0; s_if.write_n = 1'b1; s_if.writedata = '0;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_value("rst_m_chipselect", {31'b0, m_if.chipselect}, 32'd0);
      check_value("rst_m_write_n",    {31'b0, m_if.write_n},    32'd1);
      check_value("rst_m_writedata",  m_if.writedata,           32'd0);
      check_value("rst_irq",          {31'b0, irq},             32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Single pass: three patterns, P=5, irq enabled.
      write_reg(8, 32'h01); write_reg(9, 32'h02); write_reg(10, 32'h04);
      write_reg(3, 32'd3);  write_reg(2, 32'd5);
      strobes = 0;
      write_reg(0, 32'h5);
      idle(25);
      check_value("single_strobes", strobes, 32'd3);
      check_value("single_led", {24'b0, led}, 32'h04);
      bus_cycle(1, 1'b1, 1'b1, 32'd0);
      check_value("single_status", {25'b0, obs_rd[6:0]}, 32'h22);
      check_value("single_irq", {31'b0, irq}, 32'd1);

      // Loop and stop: P=1, two steps.
      write_reg(1, 32'h2);
      write_reg(3, 32'd2); write_reg(2, 32'd1);
      write_reg(0, 32'h3);
      idle(10);
      write_reg(0, 32'h0);
      strobes = 0;
      idle(5);
      check_value("stop_no_strobe", strobes, 32'd0);
      bus_cycle(1, 1'b1, 1'b1, 32'd0);
      check_value("stop_done_clear", {31'b0, obs_rd[1]}, 32'd0);

      // Asynchronous reset while strobing every cycle.
      write_reg(0, 32'h3);
      idle(3);
      @(negedge clk);
      s_if.chipselect = 1'b0; s_if.write_n = 1'b1;
      #1;
      check_value("pre_reset_strobe", {31'b0, m_if.chipselect}, {31'b0, model_strobe()});
      reset_n = 1'b0;
      #1;
      check_value("async_rst_cs", {31'b0, m_if.chipselect}, 32'd0);
      check_value("async_rst_wn", {31'b0, m_if.write_n}, 32'd1);
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         bus_cycle(a, 1'b1, 1'b1, 32'd0);
         check_value("rst_reg_zero", obs_rd, 32'd0);
      end

      // Edge config: PERIOD=0, LENGTH=0 -> eight back-to-back strobes.
      for (int i = 0; i < 8; i++) write_reg(8 + i, 32'd1 << i);
      write_reg(2, 32'd0); write_reg(3, 32'd0);
      strobes = 0;
      write_reg(0, 32'h1);
      idle(12);
      check_value("edge_strobes", strobes, 32'd8);
      check_value("edge_led", {24'b0, led}, 32'h80);
      bus_cycle(1, 1'b1, 1'b1, 32'd0);
      check_value("edge_done", {31'b0, obs_rd[1]}, 32'd1);

      // Restart with live pattern update during step 2 of 4.
      write_reg(1, 32'h2);
      write_reg(3, 32'd4); write_reg(2, 32'd3);
      write_reg(0, 32'h1);
      idle(7);
      write_reg(8, 32'hAA);
      write_reg(0, 32'h1);
      bus_cycle(1, 1'b1, 1'b1, 32'd0);
      check_value("restart_led", {24'b0, led}, 32'hAA);
      check_value("restart_status", {25'b0, obs_rd[6:0]}, 32'h01);
      idle(20);

      // Collision: DONE clear on the completion cycle -> DONE still set.
      write_reg(1, 32'h2);
      write_reg(3, 32'd2); write_reg(2, 32'd3);
      write_reg(0, 32'h1);
      wait_final("final_timeout_1");
      write_reg(1, 32'h2);
      bus_cycle(1, 1'b1, 1'b1, 32'd0);
      check_value("collide_clear", {25'b0, obs_rd[6:0]}, 32'h12);

      // Collision: RUN=1 on the completion cycle -> restart, no DONE.
      write_reg(1, 32'h2);
      write_reg(0, 32'h1);
      wait_final("final_timeout_2");
      write_reg(0, 32'h1);
      strobes = 0;
      bus_cycle(1, 1'b1, 1'b1, 32'd0);
      check_value("collide_run", {25'b0, obs_rd[6:0]}, 32'h01);
      check_value("collide_strobe", strobes, 32'd1);
      idle(10);

      // Random register traffic.
      for (int n = 0; n < 3000; n++) begin
         int r = int'($urandom_range(0, 99));
         logic [31:0] wd = $urandom;
         if (r < 3) begin
            wd[0] = ($urandom_range(0, 3) != 0);
            write_reg(0, wd);
         end else if (r < 7) begin
            write_reg(1, wd);
         end else if (r < 12) begin
            write_reg(2, ($urandom_range(0, 9) == 0) ? wd & 32'h00FF_FFFF & 32'h0000_000F : $urandom_range(0, 5));
         end else if (r < 16) begin
            write_reg(3, $urandom_range(0, 15));
         end else if (r < 28) begin
            write_reg(int'($urandom_range(8, 15)), wd);
         end else if (r < 31) begin
            write_reg(int'($urandom_range(4, 7)), wd);
         end else begin
            bus_cycle(int'($urandom_range(0, 15)), 1'($urandom), 1'b1 ^ 1'(r == 99 ? 0 : 0) ^ 1'($urandom_range(0, 7) == 0) & 1'b0, wd);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/neural_soc_led_sequencer.md
# neural_soc_led_sequencer

Autonomous LED pattern sequencer for the neural SoC. The CPU loads up to eight 8-bit patterns, a per-step hold period and a step count through an Avalon-MM slave, then sets RUN. The block replays the patterns by issuing single-cycle Avalon-MM writes to the 8-bit LED PIO data register (offset 0) with no further CPU involvement, and raises an interrupt when a non-looping sequence completes.

## Interface
- NUM_STEPS, 8, pattern slots; fixed at 8 for this revision.
- PERIOD_W, 24, width of the PERIOD register and hold counter.

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- s_address  in  4  config slave word address
- s_chipselect  in  1  slave select
- s_write_n  in  1  slave write strobe, active-low
- s_writedata  in  32  slave write data
- s_readdata  out  32  slave read data; combinational, zero wait states
- m_address  out  2  to LED PIO address; always 0
- m_chipselect  out  1  to LED PIO chipselect
- m_write_n  out  1  to LED PIO write_n
- m_writedata  out  32  to LED PIO writedata; {24'b0, pattern}
- irq  out  1  level interrupt = DONE & IRQ_EN

## Operation
- Register map (word addresses):
  - 0 CONTROL: bit0 RUN, bit1 LOOP, bit2 IRQ_EN; R/W.
  - 1 STATUS: bit0 BUSY (RO), bit1 DONE (sticky; write 1 clears), bits[6:4] current step (RO).
  - 2 PERIOD: bits[23:0]; effective P = max(PERIOD,1).
  - 3 LENGTH: bits[3:0]; effective L = 8 if value is 0 or >8, else value.
  - 8..15 PATTERN[0..7]: bits[7:0].
  - Unmapped addresses read 0; writes to them are ignored. Reads have no side effects.
- FSM states IDLE, WRITE, HOLD.
  - IDLE: master idle. A CONTROL write with RUN=1 sets step=0 and moves to WRITE.
  - WRITE, one cycle: m_chipselect=1, m_write_n=0, m_writedata={24'b0, PATTERN[step]}. If P=1, advance the step immediately (see below). Otherwise load the counter with P-2 and go to HOLD.
  - HOLD: decrement the counter each cycle. At 0, advance the step.
  - Advance: if step<L-1, then step+1 and go to WRITE. If step=L-1 and LOOP=1, then step=0 and go to WRITE. Otherwise clear RUN, set DONE, go to IDLE.
- BUSY = (state != IDLE). The last pattern written stays on the LEDs after completion or stop.
- CONTROL write with RUN=0 while busy: go to IDLE next cycle. No further master writes. DONE is not set.
- CONTROL write with RUN=1 while busy: restart at step 0 and go to WRITE next cycle.
- PATTERN, PERIOD and LENGTH writes while busy are allowed.
  - A pattern change takes effect the next time that step is written.
  - PERIOD is sampled at the next counter load.
  - LENGTH is sampled at each advance decision.
- Simultaneous events:
  - A CONTROL write in the same cycle as a natural completion: the CONTROL write wins and DONE is not set.
  - A DONE set and a STATUS clear in the same cycle: the set wins.

## Timing
- Reset values:
  - All registers 0, state IDLE, step 0.
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, irq=0.
  - Reset asserted mid-sequence drops the master strobe immediately (asynchronous).
- Start latency: the RUN write is sampled at edge N. The first master strobe is high for the cycle after edge N, sampled by the PIO at edge N+1.
- Consecutive master strobes are exactly P cycles apart. With P=1, strobes are back-to-back every cycle.
- Each strobe is exactly one cycle; the PIO has no waitrequest.
- DONE and irq assert the cycle after the HOLD/WRITE cycle that ends the final step. That is P cycles after the last strobe.
- s_readdata is valid in the same cycle as s_address.

## Test plan
- Reset: hold reset_n low mid-sequence -> master strobe deasserts immediately; all outputs and registers read 0; irq=0.
- Single pass: PATTERN[0..2]=0x01,0x02,0x04, LENGTH=3, PERIOD=5, CONTROL=0x5 -> strobes 5 cycles apart carrying 0x01,0x02,0x04; DONE=1 and irq=1 five cycles after the last strobe; BUSY=0; LED model holds 0x04.
- Loop and stop: LENGTH=2, PERIOD=1, LOOP=1 -> strobes every cycle alternating PATTERN[0]/[1]; write CONTROL=0 -> no strobe after the next cycle; DONE stays 0.
- Edge config: PERIOD=0 and LENGTH=0 -> behaves as P=1 with 8 steps, 8 back-to-back strobes, then DONE.
- Restart and live update: during step 2 of 4, write PATTERN[0]=0xAA, then CONTROL=0x1 -> next-cycle strobe carries 0xAA; step field reads 0.
- Collision: a DONE-clear write lands on the completion cycle -> DONE reads 1. A RUN=1 write lands on the completion cycle -> restart, DONE stays 0.
